// File: rtl/rvc_pack_compressor_if.sv
// rvc_pack_compressor_if
//
// Stream bundle for the RV32C packing compressor. It groups the instruction
// input handshake, the packed-word output handshake, the flush request and the
// empty status into one interface.
//
// Signals:
//   in_valid   in_inst is valid
//   in_ready   compressor accepts in_inst this cycle
//   in_inst    uncompressed RV32I instruction (bits [1:0] == 2'b11)
//   flush      level request to emit a pending halfword padded with c.nop
//   out_valid  out_word is valid
//   out_ready  downstream accepts out_word
//   out_word   packed little-endian word, bits [15:0] hold the earlier parcel
//   empty      no pending halfword and no pending output word
//
// Modports:
//   master  the side that supplies instructions and consumes packed words
//   slave   the compressor itself
interface rvc_pack_compressor_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        empty;

  modport master (
    output in_valid, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_word, empty
  );

  modport slave (
    input  in_valid, in_inst, flush, out_ready,
    output in_ready, out_valid, out_word, empty
  );
endinterface

// File: rtl/rvc_pack_compressor.sv
// rvc_pack_compressor
//
// Rewrites each incoming RV32I instruction as an RV32C halfword when an exact
// 16-bit equivalent exists, then packs the resulting 16/32-bit parcels into
// little-endian 32-bit words on a valid/ready output with a single-entry
// output register.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rvc_pack_compressor_if.slave (input/output handshakes, flush, empty)
//
// Configuration:
//   RVC_CA_COMPRESS_EN  when defined, the register-register group (c.sub,
//                       c.xor, c.or, c.and, c.add, c.mv) is compressed;
//                       otherwise those instructions pass through as 32 bits.
module rvc_pack_compressor (
  input logic                  clk,
  input logic                  rst_n,
  rvc_pack_compressor_if.slave bus
);

  typedef enum logic {
    ST_EMPTY,
    ST_HALF
  } state_t;

  state_t      state;
  logic [15:0] residue;
  logic [31:0] out_word_q;
  logic        out_valid_q;

  logic        is_c;
  logic [15:0] c_half;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic        rd_p;
  logic        rs1_p;
  logic        rs2_p;
  logic        imm6_ok;
  logic        off_i_ok;
  logic        off_s_ok;
  logic        lui_ok;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = inst[31:20];
  assign imm_s  = {inst[31:25], inst[11:7]};

  // Prime registers x8..x15 have the pattern 01xxx.
  assign rd_p  = (rd[4:3] == 2'b01);
  assign rs1_p = (rs1[4:3] == 2'b01);
  assign rs2_p = (rs2[4:3] == 2'b01);

  // A 12-bit immediate fits in 6 signed bits when bits [11:5] all match.
  assign imm6_ok  = (imm_i[11:5] == {7{imm_i[5]}});
  // Load/store offsets 0..124 step 4: only bits [6:2] may be set.
  assign off_i_ok = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0);
  assign off_s_ok = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0);
  // LUI upper immediate must be a nonzero sign extension of bits [17:12].
  assign lui_ok   = (inst[31:17] == {15{inst[17]}}) && (inst[17:12] != 6'd0);

  // Classifier: decide whether the incoming instruction has an exact
  // RV32C equivalent and build that halfword.
  always_comb begin
    is_c   = 1'b0;
    c_half = 16'h0000;
    case (opcode)
      7'b0000011: begin
        if (funct3 == 3'b010 && rd_p && rs1_p && off_i_ok) begin
          is_c   = 1'b1;
          c_half = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010 && rs1_p && rs2_p && off_s_ok) begin
          is_c   = 1'b1;
          c_half = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end
      end
      7'b0010011: begin
        case (funct3)
          3'b000: begin
            if (rd != 5'd0 && rs1 == rd && imm_i != 12'd0 && imm6_ok) begin
              is_c   = 1'b1;
              c_half = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            end else if (rs1 == 5'd0 && rd != 5'd0 && imm6_ok) begin
              is_c   = 1'b1;
              c_half = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
            end
          end
          3'b001: begin
            if (funct7 == 7'd0 && rs2 != 5'd0 && rd != 5'd0 && rs1 == rd) begin
              is_c   = 1'b1;
              c_half = {3'b000, 1'b0, rd, rs2, 2'b10};
            end
          end
          3'b101: begin
            // funct7[5] separates SRAI from SRLI and maps to the c.srai sub-op.
            if ((funct7 == 7'd0 || funct7 == 7'b0100000) && rs2 != 5'd0 &&
                rd_p && rs1 == rd) begin
              is_c   = 1'b1;
              c_half = {3'b100, 1'b0, 1'b0, funct7[5], rd[2:0], rs2, 2'b01};
            end
          end
          3'b111: begin
            if (rd_p && rs1 == rd && imm6_ok) begin
              is_c   = 1'b1;
              c_half = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
            end
          end
          default: ;
        endcase
      end
      7'b0110111: begin
        if (rd != 5'd0 && rd != 5'd2 && lui_ok) begin
          is_c   = 1'b1;
          c_half = {3'b011, inst[17], rd, inst[16:12], 2'b01};
        end
      end
      7'b0110011: begin
`ifdef RVC_CA_COMPRESS_EN
        if (funct7 == 7'd0 && funct3 == 3'b000) begin
          if (rd != 5'd0 && rs1 == rd && rs2 != 5'd0) begin
            is_c   = 1'b1;
            c_half = {4'b1001, rd, rs2, 2'b10};
          end else if (rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
            is_c   = 1'b1;
            c_half = {4'b1000, rd, rs2, 2'b10};
          end
        end else if (rd_p && rs1 == rd && rs2_p) begin
          case ({funct7, funct3})
            10'b0100000_000: begin
              is_c   = 1'b1;
              c_half = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
            end
            10'b0000000_100: begin
              is_c   = 1'b1;
              c_half = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
            end
            10'b0000000_110: begin
              is_c   = 1'b1;
              c_half = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
            end
            10'b0000000_111: begin
              is_c   = 1'b1;
              c_half = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
            end
            default: ;
          endcase
        end
`endif
      end
      default: ;
    endcase
  end

  logic accept;
  logic flush_go;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  // An input in the same cycle wins; flush only fires on an idle input.
  assign flush_go      = (state == ST_HALF) && bus.flush && !bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.empty     = (state == ST_EMPTY) && !out_valid_q;

  // Packing FSM. A drained output clears out_valid unless a new word is
  // loaded in the same cycle, which gives back-to-back words with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      residue     <= 16'h0000;
      out_word_q  <= 32'h0000_0000;
      out_valid_q <= 1'b0;
    end else begin
      if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        case (state)
          ST_EMPTY: begin
            if (is_c) begin
              residue <= c_half;
              state   <= ST_HALF;
            end else begin
              out_word_q  <= inst;
              out_valid_q <= 1'b1;
            end
          end
          ST_HALF: begin
            out_valid_q <= 1'b1;
            if (is_c) begin
              out_word_q <= {c_half, residue};
              state      <= ST_EMPTY;
            end else begin
              out_word_q <= {inst[15:0], residue};
              residue    <= inst[31:16];
            end
          end
          default: state <= ST_EMPTY;
        endcase
      end else if (flush_go) begin
        out_word_q  <= {16'h0001, residue};
        out_valid_q <= 1'b1;
        state       <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_rvc_pack_compressor.sv
// tb_rvc_pack_compressor
//
// Testbench for rvc_pack_compressor. A reference model built from a halfword
// queue (parcels in, words out) and an arithmetic classifier predicts every
// output word and handshake flag. Directed steps cover the documented
// scenarios, followed by a randomized stream with random backpressure and
// flush requests.
module tb_rvc_pack_compressor;

  logic clk;
  logic rst_n;

  rvc_pack_compressor_if bus ();

  rvc_pack_compressor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [15:0] half_q[$];
  logic [31:0] word_q[$];

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic bit is_prime(input int r);
    return (r >= 8) && (r <= 15);
  endfunction

  // Reference classifier working on decoded integer fields.
  // Returns {compressible, halfword}.
  function automatic logic [16:0] ref_compress(input logic [31:0] i);
    int opc, rd, rs1, rs2, f3, f7, imm, off, v;
    logic [6:0] o;
    logic [5:0] s;
    opc = int'(i[6:0]);
    rd  = int'(i[11:7]);
    rs1 = int'(i[19:15]);
    rs2 = int'(i[24:20]);
    f3  = int'(i[14:12]);
    f7  = int'(i[31:25]);
    imm = int'($signed(i[31:20]));
    s   = 6'(imm);
    if (opc == 'h03 && f3 == 2) begin
      off = imm;
      o   = 7'(off);
      if (is_prime(rd) && is_prime(rs1) && off >= 0 && off <= 124 && off % 4 == 0)
        return {1'b1, 3'b010, o[5:3], 3'(rs1 - 8), o[2], o[6], 3'(rd - 8), 2'b00};
    end
    if (opc == 'h23 && f3 == 2) begin
      off = int'($signed({i[31:25], i[11:7]}));
      o   = 7'(off);
      if (is_prime(rs1) && is_prime(rs2) && off >= 0 && off <= 124 && off % 4 == 0)
        return {1'b1, 3'b110, o[5:3], 3'(rs1 - 8), o[2], o[6], 3'(rs2 - 8), 2'b00};
    end
    if (opc == 'h13 && f3 == 0) begin
      if (rd == rs1 && rd != 0 && imm != 0 && imm >= -32 && imm <= 31)
        return {1'b1, 3'b000, s[5], 5'(rd), s[4:0], 2'b01};
      if (rs1 == 0 && rd != 0 && imm >= -32 && imm <= 31)
        return {1'b1, 3'b010, s[5], 5'(rd), s[4:0], 2'b01};
    end
    if (opc == 'h13 && f3 == 1 && f7 == 0 && rs2 >= 1 && rd == rs1 && rd != 0)
      return {1'b1, 3'b000, 1'b0, 5'(rd), 5'(rs2), 2'b10};
    if (opc == 'h13 && f3 == 5 && rs2 >= 1 && rd == rs1 && is_prime(rd)) begin
      if (f7 == 0)    return {1'b1, 6'b100000, 3'(rd - 8), 5'(rs2), 2'b01};
      if (f7 == 'h20) return {1'b1, 6'b100001, 3'(rd - 8), 5'(rs2), 2'b01};
    end
    if (opc == 'h13 && f3 == 7 && rd == rs1 && is_prime(rd) && imm >= -32 && imm <= 31)
      return {1'b1, 3'b100, s[5], 2'b10, 3'(rd - 8), s[4:0], 2'b01};
    if (opc == 'h37) begin
      v = int'($signed(i[31:12]));
      s = 6'(v);
      if (rd != 0 && rd != 2 && v != 0 && v >= -32 && v <= 31)
        return {1'b1, 3'b011, s[5], 5'(rd), s[4:0], 2'b01};
    end
`ifdef RVC_CA_COMPRESS_EN
    if (opc == 'h33) begin
      if (f7 == 0 && f3 == 0 && rd == rs1 && rd != 0 && rs2 != 0)
        return {1'b1, 4'b1001, 5'(rd), 5'(rs2), 2'b10};
      if (f7 == 0 && f3 == 0 && rs1 == 0 && rd != 0 && rs2 != 0)
        return {1'b1, 4'b1000, 5'(rd), 5'(rs2), 2'b10};
      if (rd == rs1 && is_prime(rd) && is_prime(rs2)) begin
        if (f7 == 'h20 && f3 == 0) return {1'b1, 6'b100011, 3'(rd - 8), 2'b00, 3'(rs2 - 8), 2'b01};
        if (f7 == 0 && f3 == 4)    return {1'b1, 6'b100011, 3'(rd - 8), 2'b01, 3'(rs2 - 8), 2'b01};
        if (f7 == 0 && f3 == 6)    return {1'b1, 6'b100011, 3'(rd - 8), 2'b10, 3'(rs2 - 8), 2'b01};
        if (f7 == 0 && f3 == 7)    return {1'b1, 6'b100011, 3'(rd - 8), 2'b11, 3'(rs2 - 8), 2'b01};
      end
    end
`endif
    return 17'h0;
  endfunction

  // One clock cycle: drive inputs, compare DUT against the model, then advance
  // the model with whatever the handshakes transfer at the coming edge.
  task automatic apply_stimulus(input logic valid, input logic [31:0] inst,
                                input logic fl, input logic ordy);
    logic        exp_valid;
    logic        rdy;
    logic [16:0] c;
    bus.in_valid  = valid;
    bus.in_inst   = inst;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
    exp_valid = (word_q.size() != 0);
    rdy       = !exp_valid || ordy;
    check_output("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    check_output("in_ready", 32'(bus.in_ready), 32'(rdy));
    check_output("empty", 32'(bus.empty), 32'(!exp_valid && half_q.size() == 0));
    if (exp_valid) check_output("out_word", bus.out_word, word_q[0]);
    if (exp_valid && ordy) void'(word_q.pop_front());
    if (valid && rdy) begin
      c = ref_compress(inst);
      if (c[16]) half_q.push_back(c[15:0]);
      else begin
        half_q.push_back(inst[15:0]);
        half_q.push_back(inst[31:16]);
      end
    end else if (!valid && fl && rdy && half_q.size() == 1) begin
      half_q.push_back(16'h0001);
    end
    while (half_q.size() >= 2) begin
      word_q.push_back({half_q[1], half_q[0]});
      void'(half_q.pop_front());
      void'(half_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 1) == 1) return 5'(8 + $urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  // Random instruction biased towards compressible shapes.
  function automatic logic [31:0] gen_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm, off;
    logic [19:0] u;
    logic [6:0]  f7;
    logic [2:0]  f3;
    rd  = pick_reg();
    rs1 = ($urandom_range(0, 9) < 7) ? rd : pick_reg();
    rs2 = pick_reg();
    imm = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 80)) - 12'd40;
    off = ($urandom_range(0, 2) != 0) ? 12'($urandom_range(0, 33) * 4) : imm;
    f7  = ($urandom_range(0, 3) == 0) ? 7'h20 : (($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h00);
    case ($urandom_range(0, 9))
      0: return {off, rs1, 3'b010, rd, 7'h03};
      1: return {off[11:5], rs2, rs1, 3'b010, off[4:0], 7'h23};
      2: return {imm, rs1, 3'b000, rd, 7'h13};
      3: return {imm, 5'd0, 3'b000, rd, 7'h13};
      4: begin
        u = ($urandom_range(0, 1) == 1) ? 20'($signed(imm[5:0])) : 20'($urandom);
        return {u, rd, 7'h37};
      end
      5: begin
        f3 = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
        return {f7, 5'($urandom), rs1, f3, rd, 7'h13};
      end
      6: return {imm, rs1, 3'b111, rd, 7'h13};
      7, 8: begin
        f3 = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'b000;
        if ($urandom_range(0, 4) == 0) rs1 = 5'd0;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      default: return 32'($urandom) | 32'h3;
    endcase
  endfunction

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    $display("[TB] reset state");
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_word", bus.out_word, 32'd0);
    check_output("rst_empty", 32'(bus.empty), 32'd1);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Pair of compressed instructions (the add pairs only with the CA group on).
    $display("[TB] pair of compressed");
    apply_stimulus(1'b1, 32'h00140413, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h00B50533, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Pass-through from EMPTY, state stays EMPTY.
    $display("[TB] pass-through");
    apply_stimulus(1'b1, 32'h003100B3, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Straddle then flush; flush in EMPTY afterwards is a no-op.
    $display("[TB] straddle and flush");
    apply_stimulus(1'b1, 32'h00140413, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h003100B3, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // Backpressure: word held stable, input refused, then drain and accept together.
    $display("[TB] backpressure");
    apply_stimulus(1'b1, 32'h003100B3, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) apply_stimulus(1'b1, 32'h00140413, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h00140413, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h00140413, 1'b1, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // CA-group add: compressed or passed through depending on the build.
    $display("[TB] CA group add");
    apply_stimulus(1'b1, 32'h00B50533, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset in HALF with a pending word.
    $display("[TB] async reset");
    apply_stimulus(1'b1, 32'h00140413, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h003100B3, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("areset_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("areset_empty", 32'(bus.empty), 32'd1);
    half_q.delete();
    word_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized stream with random backpressure and flush.
    $display("[TB] random stream");
    for (int n = 0; n < 600; n++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0), gen_inst(),
                     1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) != 0));
    end
    for (int n = 0; n < 10 && (half_q.size() != 0 || word_q.size() != 0); n++)
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
